// File: rtl/boot_rom_tcdm_adapter.sv
// TCDM read front-end for the boot ROM macro: grants reads, drives the ROM pins
// and returns in-order responses through a small fall-through response buffer.
module boot_rom_tcdm_adapter #(
  parameter int unsigned ROM_ADDR_WIDTH = 13,
  parameter logic [31:0] ROM_BASE_ADDR  = 32'h1A00_0000,
  parameter int unsigned RSP_DEPTH      = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic [31:0]               add_i,
  input  logic                      we_i,
  input  logic [3:0]                be_i,
  input  logic [31:0]               wdata_i,
  output logic                      gnt_o,
  output logic                      r_valid_o,
  output logic [31:0]               r_rdata_o,
  output logic                      r_opc_o,
  input  logic                      r_ready_i,
  output logic                      rom_csn_o,
  output logic [ROM_ADDR_WIDTH-3:0] rom_add_o,
  input  logic [31:0]               rom_rdata_i
);

  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic                      r_pipe_vld;
  logic                      r_pipe_err;
  logic [31:0]               r_buf_data [RSP_DEPTH];
  logic [RSP_DEPTH-1:0]      r_buf_err;
  logic [PTR_W-1:0]          r_wr_ptr;
  logic [PTR_W-1:0]          r_rd_ptr;
  logic [CNT_W-1:0]          r_buf_cnt;
  logic [CNT_W-1:0]          w_buf_cnt_nxt;
  logic [ROM_ADDR_WIDTH-3:0] r_rom_add;

  logic        w_in_win;
  logic        w_gnt;
  logic        w_rom_acc;
  logic        w_buf_empty;
  logic [31:0] w_pipe_data;
  logic        w_pop;
  logic        w_push;
  logic        w_buf_pop;
  logic        w_unused;

  assign w_unused    = ^{be_i, wdata_i, add_i[1:0]};
  assign w_in_win    = (add_i[31:ROM_ADDR_WIDTH] == ROM_BASE_ADDR[31:ROM_ADDR_WIDTH]);
  // Registered count only: keeps r_ready_i out of the grant path.
  assign w_gnt       = req_i & ~rst_i & (r_cnt < DEPTH_C);
  assign w_rom_acc   = w_gnt & ~we_i & w_in_win;
  assign gnt_o       = w_gnt;
  assign rom_csn_o   = ~w_rom_acc;
  assign rom_add_o   = w_rom_acc ? add_i[ROM_ADDR_WIDTH-1:2] : r_rom_add;
  assign w_buf_empty = (r_buf_cnt == {CNT_W{1'b0}});
  assign w_pipe_data = r_pipe_err ? 32'h0000_0000 : rom_rdata_i;
  assign w_pop       = r_valid_o & r_ready_i;
  assign w_push      = r_pipe_vld & ~(w_buf_empty & r_ready_i);
  assign w_buf_pop   = w_pop & ~w_buf_empty;

  always_comb begin
    r_valid_o = 1'b0;
    r_rdata_o = 32'h0000_0000;
    r_opc_o   = 1'b0;
    if (rst_i) begin
      r_valid_o = 1'b0;
    end else if (!w_buf_empty) begin
      r_valid_o = 1'b1;
      r_rdata_o = r_buf_data[r_rd_ptr];
      r_opc_o   = r_buf_err[r_rd_ptr];
    end else if (r_pipe_vld) begin
      r_valid_o = 1'b1;
      r_rdata_o = w_pipe_data;
      r_opc_o   = r_pipe_err;
    end else begin
      r_valid_o = 1'b0;
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_gnt, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
      2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_comb begin
    w_buf_cnt_nxt = r_buf_cnt;
    case ({w_push, w_buf_pop})
      2'b10:   w_buf_cnt_nxt = r_buf_cnt + CNT_W'(1);
      2'b01:   w_buf_cnt_nxt = r_buf_cnt - CNT_W'(1);
      default: w_buf_cnt_nxt = r_buf_cnt;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt      <= {CNT_W{1'b0}};
      r_pipe_vld <= 1'b0;
      r_pipe_err <= 1'b0;
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_buf_cnt  <= {CNT_W{1'b0}};
      r_buf_err  <= {RSP_DEPTH{1'b0}};
      r_rom_add  <= {(ROM_ADDR_WIDTH-2){1'b0}};
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_pipe_vld <= w_gnt;
      r_pipe_err <= w_gnt & ~w_rom_acc;
      r_buf_cnt  <= w_buf_cnt_nxt;
      if (w_rom_acc) begin
        r_rom_add <= add_i[ROM_ADDR_WIDTH-1:2];
      end
      if (w_push) begin
        r_buf_err[r_wr_ptr] <= r_pipe_err;
        r_wr_ptr            <= ptr_inc(r_wr_ptr);
      end
      if (w_buf_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
    end
  end

  // Payload storage needs no reset; occupancy is tracked by r_buf_cnt.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push) begin
      r_buf_data[r_wr_ptr] <= w_pipe_data;
    end
  end

endmodule
